// File: rtl/sm_pkg.sv
// sm_pkg: shared readout state, report header layout and header builder for the surveillance statistics stages
package sm_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, ERR} rd_state_e;
  localparam int SEQ_LSB = 16;
  localparam int MISSED_BIT = 15;
  localparam int NTILES_LSB = 0;
  function automatic logic [31:0] hdr_word(input logic [15:0] seq, input logic missed, input logic [7:0] ntiles);
    hdr_word = '0;
    hdr_word[SEQ_LSB+:16] = seq;
    hdr_word[MISSED_BIT] = missed;
    hdr_word[NTILES_LSB+:8] = ntiles;
  endfunction
endpackage

// File: rtl/sm_be_dest_stats_if.sv
// sm_be_dest_stats_if: BE destination input (be_valid/be_dest) and report stream (out_data/out_valid/out_ready/out_last); slave is the stats stage, master its environment
interface sm_be_dest_stats_if #(parameter int NUM_TILES = 9);
  localparam int TILE_WIDTH = NUM_TILES > 1 ? $clog2(NUM_TILES) : 1;
  logic be_valid;
  logic [TILE_WIDTH-1:0] be_dest;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  modport master(output be_valid, be_dest, out_ready, input out_data, out_valid, out_last);
  modport slave(input be_valid, be_dest, out_ready, output out_data, out_valid, out_last);
endinterface

// File: rtl/sm_window_timer.sv
// sm_window_timer: free-running modulo-WINDOW_CYCLES counter; ports clk, rst, tc_o (high in the last cycle of each window)
module sm_window_timer #(
  parameter int WINDOW_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tc_o
);
  localparam int W = WINDOW_CYCLES > 1 ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(WINDOW_CYCLES - 1);
  logic [W-1:0] cnt_q;
  assign tc_o = cnt_q == LAST;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/sm_be_dest_stats.sv
// sm_be_dest_stats: per-destination BE packet counters over fixed windows, snapshot streamed as header/tile words/invalid-dest word on bus (clk, rst, bus.slave); SM_BE_STATS_SATURATE_EN makes counters saturate instead of wrap
module sm_be_dest_stats
  import sm_pkg::*;
#(
  parameter int NUM_TILES     = 9,
  parameter int CNT_WIDTH     = 16,
  parameter int WINDOW_CYCLES = 100000
) (
  input logic clk,
  input logic rst,
  sm_be_dest_stats_if.slave bus
);
  localparam int TILE_WIDTH = NUM_TILES > 1 ? $clog2(NUM_TILES) : 1;
  localparam logic [TILE_WIDTH:0] NT = (TILE_WIDTH + 1)'(NUM_TILES);
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  function automatic cnt_t inc(input cnt_t c);
`ifdef SM_BE_STATS_SATURATE_EN
    return &c ? c : c + 1'b1;
`else
    return c + 1'b1;
`endif
  endfunction
  logic tc, snap, acc, hit_tile;
  cnt_t cnt_q [NUM_TILES];
  cnt_t cnt_d [NUM_TILES];
  cnt_t sh_q [NUM_TILES];
  cnt_t inv_q, inv_d, sh_inv_q;
  logic [15:0] seq_q;
  logic missed_q;
  rd_state_e state_q;
  logic [TILE_WIDTH-1:0] idx_q;
  logic [31:0] data_q;
  logic valid_q, last_q;
  sm_window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (.clk(clk), .rst(rst), .tc_o(tc));
  assign hit_tile = {1'b0, bus.be_dest} < NT;
  assign snap = tc && state_q == IDLE;
  assign acc = valid_q && bus.out_ready;
  assign bus.out_data = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last = last_q;
  always_comb begin
    for (int i = 0; i < NUM_TILES; i++)
      cnt_d[i] = (bus.be_valid && hit_tile && bus.be_dest == TILE_WIDTH'(i)) ? inc(tc ? '0 : cnt_q[i]) : (tc ? '0 : cnt_q[i]);
    inv_d = (bus.be_valid && !hit_tile) ? inc(tc ? '0 : inv_q) : (tc ? '0 : inv_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      sh_q <= '{default: '0};
      inv_q <= '0;
      sh_inv_q <= '0;
      seq_q <= '0;
      missed_q <= 1'b0;
      state_q <= IDLE;
      idx_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      inv_q <= inv_d;
      if (snap) begin
        sh_q <= cnt_q;
        sh_inv_q <= inv_q;
        seq_q <= seq_q + 1'b1;
        missed_q <= 1'b0;
      end else if (tc) missed_q <= 1'b1;
      case (state_q)
        IDLE: if (snap) begin
          state_q <= HDR;
          valid_q <= 1'b1;
          data_q <= hdr_word(seq_q, missed_q, 8'(NUM_TILES));
        end
        HDR: if (acc) begin
          state_q <= DATA;
          idx_q <= '0;
          data_q <= 32'(sh_q[0]);
        end
        DATA: if (acc) begin
          if (idx_q == TILE_WIDTH'(NUM_TILES - 1)) begin
            state_q <= ERR;
            data_q <= 32'(sh_inv_q);
            last_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
            data_q <= 32'(sh_q[idx_q + 1'b1]);
          end
        end
        default: if (acc) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q <= 1'b0;
          data_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sm_be_dest_stats.sv
// tb_sm_be_dest_stats: directed and random stimulus against a queue-based report model plus literal report checks
module tb_sm_be_dest_stats;
  localparam int NT = 9;
  localparam int CW = 4;
  localparam int WC = 64;
`ifdef SM_BE_STATS_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sm_be_dest_stats_if #(.NUM_TILES(NT)) bus();
  sm_be_dest_stats #(.NUM_TILES(NT), .CNT_WIDTH(CW), .WINDOW_CYCLES(WC)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int live [NT];
  int inv, mt, seq;
  bit missed;
  logic [31:0] q [$];
  logic [31:0] got [$];
  function automatic int bump(input int x);
    if (SAT) return x == (1 << CW) - 1 ? x : x + 1;
    return (x + 1) % (1 << CW);
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic model_reset();
    foreach (live[i]) live[i] = 0;
    inv = 0;
    mt = 0;
    seq = 0;
    missed = 1'b0;
    q.delete();
  endtask
  task automatic step(input bit v, input int d, input bit r, input bit rs);
    bit busy, tc;
    bus.be_valid = v;
    bus.be_dest = 4'(d);
    bus.out_ready = r;
    rst = rs;
    #1;
    if (!rs && bus.out_valid && r) got.push_back(bus.out_data);
    @(posedge clk);
    if (rs) model_reset();
    else begin
      busy = q.size() != 0;
      if (busy && r) void'(q.pop_front());
      tc = mt == WC - 1;
      mt = (mt + 1) % WC;
      if (tc) begin
        if (!busy) begin
          q.push_back({16'(seq), missed, 7'b0, 8'(NT)});
          foreach (live[i]) q.push_back(32'(live[i]));
          q.push_back(32'(inv));
          seq = (seq + 1) % 65536;
          missed = 1'b0;
        end else missed = 1'b1;
        foreach (live[i]) live[i] = 0;
        inv = 0;
      end
      if (v) begin
        if (d < NT) live[d] = bump(live[d]);
        else inv = bump(inv);
      end
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("out_data", bus.out_data, q.size() != 0 ? q[0] : 32'h0);
    chk("out_last", 32'(bus.out_last), 32'(q.size() == 1));
  endtask
  task automatic wait_burst(input string n);
    got.delete();
    for (int k = 0; k < 300 && got.size() < NT + 2; k++) step(1'b0, 0, 1'b1, 1'b0);
    chk(n, 32'(got.size()), 32'(NT + 2));
  endtask
  initial begin
    model_reset();
    bus.be_valid = 1'b0;
    bus.be_dest = '0;
    bus.out_ready = 1'b1;
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data", bus.out_data, 32'h0);
    chk("rst_last", 32'(bus.out_last), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 3, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    for (int k = 0; k < 2; k++) step(1'b1, 8, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 12, 1'b1, 1'b0);
    wait_burst("p1_len");
    chk("p1_hdr", got[0], 32'h0000_0009);
    chk("p1_tile0", got[1], 32'd0);
    chk("p1_tile3", got[4], 32'd5);
    chk("p1_tile8", got[9], 32'd2);
    chk("p1_inv", got[10], 32'd3);
    while (mt != WC - 1) step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 0, 1'b1, 1'b0);
    wait_burst("p2a_len");
    chk("p2a_hdr", got[0], 32'h0001_0009);
    chk("p2a_tile0", got[1], 32'd0);
    wait_burst("p2b_len");
    chk("p2b_hdr", got[0], 32'h0002_0009);
    chk("p2b_tile0", got[1], 32'd1);
    for (int k = 0; k < 200; k++) step(1'b0, 0, 1'b0, 1'b0);
    wait_burst("p3a_len");
    chk("p3a_hdr", got[0], 32'h0003_0009);
    wait_burst("p3b_len");
    chk("p3b_hdr_missed", got[0], 32'h0004_8009);
    wait_burst("p3c_len");
    chk("p3c_hdr_clear", got[0], 32'h0005_0009);
    while (mt != 0) step(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1, 1'b1, 1'b0);
    wait_burst("p4_len");
    chk("p4_tile1", got[2], SAT ? 32'd15 : 32'd4);
    for (int k = 0; k < 1500; k++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'b0);
    for (int k = 0; k < 100 && q.size() != 0; k++) step(1'b0, 0, 1'b1, 1'b0);
    while (mt != WC - 1) step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    got.delete();
    for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1, 1'b0);
    chk("p6_words_before_rst", 32'(got.size()), 32'd5);
    chk("p6_valid_before_rst", 32'(bus.out_valid), 32'h1);
    step(1'b0, 0, 1'b1, 1'b1);
    chk("p6_valid_after_rst", 32'(bus.out_valid), 32'h0);
    wait_burst("p6_len");
    chk("p6_hdr", got[0], 32'h0000_0009);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
